// File: rtl/counter_nbit_updown.sv
// counter_nbit_updown: modulo-MODULUS up/down counter with parallel load, terminal count and wrap pulse.
// Optional macro COUNTER_SATURATE_EN: hold at the range ends instead of wrapping; wrap then never asserts.
module counter_nbit_updown #(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] counter,
   output logic             tc,
   output logic             wrap
);

   // MODULUS may equal 2^WIDTH, so the load bound is compared one bit wider.
   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 64'd1);
   localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if ({1'b0, v} >= MOD_X) begin
         r = MAX_C;
      end else begin
         r = v;
      end
      return r;
   endfunction

   logic [WIDTH-1:0] counter_r;
   logic [WIDTH-1:0] counter_nxt_s;
   logic             wrap_r;
   logic             wrap_nxt_s;
   logic             at_max_s;
   logic             at_zero_s;
   logic             tc_s;

   // Terminal-count detection for the current direction.
   always_comb begin
      at_max_s  = (counter_r == MAX_C);
      at_zero_s = (counter_r == ZERO_C);
      if (up_dn) begin
         tc_s = at_max_s;
      end else begin
         tc_s = at_zero_s;
      end
   end

   // Next count: load beats enable; end-of-range behaviour depends on build mode.
   always_comb begin
      counter_nxt_s = counter_r;
      wrap_nxt_s    = 1'b0;
      if (load) begin
         counter_nxt_s = clamp_load(load_val);
      end else if (en) begin
         if (up_dn) begin
            if (at_max_s) begin
`ifdef COUNTER_SATURATE_EN
               counter_nxt_s = MAX_C;
`else
               counter_nxt_s = ZERO_C;
               wrap_nxt_s    = 1'b1;
`endif
            end else begin
               counter_nxt_s = counter_r + ONE_C;
            end
         end else begin
            if (at_zero_s) begin
`ifdef COUNTER_SATURATE_EN
               counter_nxt_s = ZERO_C;
`else
               counter_nxt_s = MAX_C;
               wrap_nxt_s    = 1'b1;
`endif
            end else begin
               counter_nxt_s = counter_r - ONE_C;
            end
         end
      end else begin
         counter_nxt_s = counter_r;
      end
   end

   // State register with synchronous reset overriding load and enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         counter_r <= ZERO_C;
         wrap_r    <= 1'b0;
      end else begin
         counter_r <= counter_nxt_s;
         wrap_r    <= wrap_nxt_s;
      end
   end

   assign counter = counter_r;
   assign wrap    = wrap_r;
   assign tc      = tc_s;

endmodule

// File: tb/tb_counter_nbit_updown.sv
// tb_counter_nbit_updown: directed checks of counter_nbit_updown (WIDTH=4, MODULUS=10 and MODULUS=16).
// Expectations follow COUNTER_SATURATE_EN when the bench is built with it.
module tb_counter_nbit_updown;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] counter;
   logic       tc;
   logic       wrap;
   logic [3:0] counter16;
   logic       tc16;
   logic       wrap16;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   counter_nbit_updown #(.WIDTH(4), .MODULUS(10)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .counter(counter), .tc(tc), .wrap(wrap)
   );

   counter_nbit_updown #(.WIDTH(4), .MODULUS(16)) dut16 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .counter(counter16), .tc(tc16), .wrap(wrap16)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd5; up_dn = 1'b1;
      tick();
      tick();
      checks++;
      if (counter !== 4'd0) begin errors++; $display("FAIL reset_counter got %0d want 0", counter); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
      checks++;
      if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc_up got %b want 0", tc); end
      checks++;
      if (counter16 !== 4'd0) begin errors++; $display("FAIL reset_counter16 got %0d want 0", counter16); end
      up_dn = 1'b0;
      #1;
      checks++;
      if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down got %b want 1", tc); end
   endtask

   task automatic test_count_up;
      logic [3:0] exp_c [12];
      logic       exp_w [12];
      logic [3:0] prev;
`ifdef COUNTER_SATURATE_EN
      exp_c = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_c = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
      rst = 1'b0; load = 1'b0; en = 1'b1; up_dn = 1'b1;
      prev = 4'd0;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++;
         if (tc !== (prev == 4'd9)) begin errors++; $display("FAIL up_tc step %0d got %b at count %0d", i, tc, prev); end
         tick();
         checks++;
         if (counter !== exp_c[i]) begin errors++; $display("FAIL up_count step %0d got %0d want %0d", i, counter, exp_c[i]); end
         checks++;
         if (wrap !== exp_w[i]) begin errors++; $display("FAIL up_wrap step %0d got %b want %b", i, wrap, exp_w[i]); end
         prev = exp_c[i];
      end
   endtask

   task automatic test_load_down;
      logic [3:0] exp_c [7];
      logic       exp_w [7];
      logic [3:0] prev;
`ifdef COUNTER_SATURATE_EN
      exp_c = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_c = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
      exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
      load = 1'b1; load_val = 4'd5; en = 1'b1; up_dn = 1'b0;
      tick();
      checks++;
      if (counter !== 4'd5) begin errors++; $display("FAIL load5 got %0d want 5", counter); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL load5_wrap got %b want 0", wrap); end
      load = 1'b0;
      prev = 4'd5;
      for (int i = 0; i < 7; i++) begin
         #1;
         checks++;
         if (tc !== (prev == 4'd0)) begin errors++; $display("FAIL down_tc step %0d got %b at count %0d", i, tc, prev); end
         tick();
         checks++;
         if (counter !== exp_c[i]) begin errors++; $display("FAIL down_count step %0d got %0d want %0d", i, counter, exp_c[i]); end
         checks++;
         if (wrap !== exp_w[i]) begin errors++; $display("FAIL down_wrap step %0d got %b want %b", i, wrap, exp_w[i]); end
         prev = exp_c[i];
      end
   endtask

   task automatic test_load_clamp;
      logic [3:0] vals [6];
      logic       ens  [6];
      logic       ups  [6];
      logic [3:0] exps [6];
      vals = '{4'd14, 4'd3, 4'd10, 4'd9, 4'd0, 4'd15};
      ens  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      ups  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      exps = '{4'd9, 4'd3, 4'd9, 4'd9, 4'd0, 4'd9};
      load = 1'b1;
      for (int i = 0; i < 6; i++) begin
         load_val = vals[i]; en = ens[i]; up_dn = ups[i];
         tick();
         checks++;
         if (counter !== exps[i]) begin errors++; $display("FAIL load_clamp val %0d got %0d want %0d", vals[i], counter, exps[i]); end
         checks++;
         if (wrap !== 1'b0) begin errors++; $display("FAIL load_nowrap val %0d got %b want 0", vals[i], wrap); end
      end
      load = 1'b0;
   endtask

   task automatic test_reset_mid;
      load = 1'b1; load_val = 4'd5; en = 1'b0; up_dn = 1'b1;
      tick();
      load = 1'b0; en = 1'b1;
      tick();
      checks++;
      if (counter !== 4'd6) begin errors++; $display("FAIL mid_pre got %0d want 6", counter); end
      rst = 1'b1; load = 1'b1; load_val = 4'd3;
      tick();
      checks++;
      if (counter !== 4'd0) begin errors++; $display("FAIL mid_rst got %0d want 0", counter); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL mid_rst_wrap got %b want 0", wrap); end
      rst = 1'b0; load = 1'b0;
      tick();
      checks++;
      if (counter !== 4'd1) begin errors++; $display("FAIL mid_resume got %0d want 1", counter); end
      // reset at the top of the range must suppress the wrap pulse
      load = 1'b1; load_val = 4'd9;
      tick();
      load = 1'b0; rst = 1'b1;
      tick();
      checks++;
      if (counter !== 4'd0) begin errors++; $display("FAIL rst_at_max got %0d want 0", counter); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL rst_at_max_wrap got %b want 0", wrap); end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic       dirs [4];
      logic [3:0] exps [4];
      logic [3:0] bc [2];
      logic       bw [2];
      dirs = '{1'b1, 1'b0, 1'b1, 1'b0};
      exps = '{4'd6, 4'd5, 4'd6, 4'd5};
`ifdef COUNTER_SATURATE_EN
      bc = '{4'd0, 4'd1};
      bw = '{1'b0, 1'b0};
`else
      bc = '{4'd9, 4'd0};
      bw = '{1'b1, 1'b1};
`endif
      load = 1'b1; load_val = 4'd5; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up_dn = dirs[i];
         tick();
         checks++;
         if (counter !== exps[i]) begin errors++; $display("FAIL dir_change step %0d got %0d want %0d", i, counter, exps[i]); end
      end
      load = 1'b1; load_val = 4'd0; en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         up_dn = (i == 1);
         tick();
         checks++;
         if (counter !== bc[i]) begin errors++; $display("FAIL b2b_count step %0d got %0d want %0d", i, counter, bc[i]); end
         checks++;
         if (wrap !== bw[i]) begin errors++; $display("FAIL b2b_wrap step %0d got %b want %b", i, wrap, bw[i]); end
      end
   endtask

   task automatic test_saturate;
      logic [3:0] up_c [5];
      logic       up_w [5];
      logic [3:0] dn_c [3];
      logic       dn_w [3];
`ifdef COUNTER_SATURATE_EN
      up_c = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
      up_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      dn_c = '{4'd0, 4'd0, 4'd0};
      dn_w = '{1'b0, 1'b0, 1'b0};
`else
      up_c = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
      up_w = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      dn_c = '{4'd0, 4'd9, 4'd8};
      dn_w = '{1'b0, 1'b1, 1'b0};
`endif
      load = 1'b1; load_val = 4'd7; en = 1'b0; up_dn = 1'b1;
      tick();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (counter !== up_c[i]) begin errors++; $display("FAIL end_up step %0d got %0d want %0d", i, counter, up_c[i]); end
         checks++;
         if (wrap !== up_w[i]) begin errors++; $display("FAIL end_up_wrap step %0d got %b want %b", i, wrap, up_w[i]); end
      end
      load = 1'b1; load_val = 4'd1; en = 1'b0; up_dn = 1'b0;
      tick();
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (counter !== dn_c[i]) begin errors++; $display("FAIL end_dn step %0d got %0d want %0d", i, counter, dn_c[i]); end
         checks++;
         if (wrap !== dn_w[i]) begin errors++; $display("FAIL end_dn_wrap step %0d got %b want %b", i, wrap, dn_w[i]); end
      end
   endtask

   task automatic test_hold_tc;
      logic exp_tc;
      load = 1'b1; load_val = 4'd15; en = 1'b0;
      tick();
      load = 1'b0;
      for (int i = 0; i < 8; i++) begin
         up_dn = ((i % 2) == 1);
         exp_tc = ((i % 2) == 1);
         #1;
         checks++;
         if (tc16 !== exp_tc) begin errors++; $display("FAIL hold16_tc_max step %0d got %b want %b", i, tc16, exp_tc); end
         checks++;
         if (tc !== exp_tc) begin errors++; $display("FAIL hold10_tc_max step %0d got %b want %b", i, tc, exp_tc); end
         tick();
         checks++;
         if (counter16 !== 4'd15) begin errors++; $display("FAIL hold16_count step %0d got %0d want 15", i, counter16); end
         checks++;
         if (counter !== 4'd9) begin errors++; $display("FAIL hold10_count step %0d got %0d want 9", i, counter); end
         checks++;
         if (wrap16 !== 1'b0) begin errors++; $display("FAIL hold16_wrap step %0d got %b want 0", i, wrap16); end
      end
      load = 1'b1; load_val = 4'd0;
      tick();
      load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         up_dn = ((i % 2) == 1);
         exp_tc = ((i % 2) == 0);
         #1;
         checks++;
         if (tc16 !== exp_tc) begin errors++; $display("FAIL hold16_tc_zero step %0d got %b want %b", i, tc16, exp_tc); end
         tick();
         checks++;
         if (counter16 !== 4'd0) begin errors++; $display("FAIL hold16_zero step %0d got %0d want 0", i, counter16); end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
      test_reset();
      test_count_up();
      test_load_down();
      test_load_clamp();
      test_reset_mid();
      test_back_to_back();
      test_saturate();
      test_hold_tc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
